zap_cp_responder: RTL and testbench

Coprocessor-side responder for the core's coprocessor handshake (dav/word/reg in, done out). Sits outside the pipeline, opposite the predecode stage that stalls decode and presents an MRC/MCR/LDC/STC/CDP word. Implements a 16-entry 32-bit coprocessor register bank addressed by CRn. Services MCR (core register to CP register) and MRC (CP register to core register) through a core register-file side port. Every other coprocessor word, or a word for a different coprocessor number, is completed immediately with an undefined flag.

---
 rtl/zap_cp_responder.sv | 117 +++++++++++
 tb/tb_zap_cp_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/zap_cp_responder.sv
// zap_cp_responder: coprocessor-side responder with a 16x32 CRn register bank servicing MCR/MRC.
// Define CP_ACCESS_CHECK_EN to refuse user-mode MCR/MRC with undef.
module zap_cp_responder #(
    parameter int          PHY_REGS = 46,
    parameter int          CP_NUM   = 15,
    parameter logic [31:0] ID_VALUE = 32'h4100_0000,
    parameter logic [15:0] RO_MASK  = 16'h0001
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic [31:0]                 i_cpsr_ff,
    input  logic                        i_copro_dav_ff,
    input  logic [31:0]                 i_copro_word_ff,
    input  logic [$clog2(PHY_REGS)-1:0] i_copro_reg_ff,
    output logic                        o_copro_done,
    output logic                        o_copro_undef,
    output logic                        o_reg_rd_en,
    output logic [$clog2(PHY_REGS)-1:0] o_reg_rd_index,
    input  logic [31:0]                 i_reg_rd_data,
    output logic                        o_reg_wr_en,
    output logic [$clog2(PHY_REGS)-1:0] o_reg_wr_index,
    output logic [31:0]                 o_reg_wr_data,
    output logic [31:0]                 o_cp_ctrl
);
    localparam int IW = $clog2(PHY_REGS);

    typedef enum logic [2:0] {IDLE, DECODE, READ, CAPTURE, WRITE, DONE} state_t;

    state_t      state_q;
    logic [31:0] word_q;
    logic [IW-1:0] idx_q;
    logic        done_q, undef_q, rd_en_q, wr_en_q;
    logic [31:0] wr_data_q;
    logic [31:0] bank_q [16];
    logic [3:0]  crn;
    logic        is_cp, is_mcr, is_mrc, refuse, dav;
    logic        unused_bits;

    assign dav    = i_copro_dav_ff;
    assign crn    = word_q[19:16];
    assign is_cp  = word_q[27:24] == 4'b1110 && word_q[4] && word_q[11:8] == 4'(CP_NUM);
    assign is_mcr = is_cp && !word_q[20];
    assign is_mrc = is_cp && word_q[20];
`ifdef CP_ACCESS_CHECK_EN
    assign refuse = i_cpsr_ff[4:0] == 5'b10000;
`else
    assign refuse = 1'b0;
`endif
    assign unused_bits = ^{i_cpsr_ff, word_q[31:28], word_q[23:21], word_q[15:12], word_q[7:5], word_q[3:0]};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            word_q    <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            undef_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            for (int i = 0; i < 16; i++) bank_q[i] <= '0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE: if (dav) begin
                    word_q  <= i_copro_word_ff;
                    idx_q   <= i_copro_reg_ff;
                    state_q <= DECODE;
                end
                DECODE: begin
                    if (!dav) begin
                        state_q <= IDLE;
                    end else if (is_mcr && !refuse) begin
                        rd_en_q <= 1'b1;
                        state_q <= READ;
                    end else if (is_mrc && !refuse) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= crn == 4'd0 ? ID_VALUE : bank_q[crn];
                        state_q   <= WRITE;
                    end else begin
                        done_q  <= 1'b1;
                        undef_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                READ: state_q <= dav ? CAPTURE : IDLE;
                CAPTURE: begin
                    // CRn=0 is the ID register and never holds written data
                    if (dav && crn != 4'd0 && !RO_MASK[crn]) bank_q[crn] <= i_reg_rd_data;
                    done_q  <= dav;
                    state_q <= dav ? DONE : IDLE;
                end
                WRITE: begin
                    done_q  <= dav;
                    state_q <= dav ? DONE : IDLE;
                end
                DONE: if (!dav) begin
                    done_q  <= 1'b0;
                    undef_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes are gated by dav so a flush in the strobe cycle issues nothing
    assign o_reg_rd_en    = rd_en_q && dav;
    assign o_reg_wr_en    = wr_en_q && dav;
    assign o_reg_rd_index = idx_q;
    assign o_reg_wr_index = idx_q;
    assign o_reg_wr_data  = wr_data_q;
    assign o_copro_done   = done_q;
    assign o_copro_undef  = undef_q;
    assign o_cp_ctrl      = bank_q[1];
endmodule

// File: tb/tb_zap_cp_responder.sv
// tb_zap_cp_responder: scoreboard bench with a behavioural bank model and randomized MCR/MRC/other traffic.
module tb_zap_cp_responder;
    localparam int          PHY_REGS = 46;
    localparam int          IW       = $clog2(PHY_REGS);
    localparam logic [31:0] ID_VALUE = 32'h4100_0000;
    localparam logic [15:0] RO_MASK  = 16'h0001;
    localparam logic [4:0]  USR      = 5'b10000;
    localparam logic [4:0]  SVC      = 5'b10011;

    logic          i_clk = 0, i_reset_n = 0, i_copro_dav_ff = 0;
    logic [31:0]   i_cpsr_ff = 0, i_copro_word_ff = 0, i_reg_rd_data = 0;
    logic [IW-1:0] i_copro_reg_ff = 0;
    logic          o_copro_done, o_copro_undef, o_reg_rd_en, o_reg_wr_en;
    logic [IW-1:0] o_reg_rd_index, o_reg_wr_index;
    logic [31:0]   o_reg_wr_data, o_cp_ctrl;

    zap_cp_responder dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_cpsr_ff(i_cpsr_ff),
        .i_copro_dav_ff(i_copro_dav_ff), .i_copro_word_ff(i_copro_word_ff),
        .i_copro_reg_ff(i_copro_reg_ff), .o_copro_done(o_copro_done),
        .o_copro_undef(o_copro_undef), .o_reg_rd_en(o_reg_rd_en),
        .o_reg_rd_index(o_reg_rd_index), .i_reg_rd_data(i_reg_rd_data),
        .o_reg_wr_en(o_reg_wr_en), .o_reg_wr_index(o_reg_wr_index),
        .o_reg_wr_data(o_reg_wr_data), .o_cp_ctrl(o_cp_ctrl)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {int cyc; logic [31:0] a; logic [31:0] b;} exp_t;
    exp_t        rd_q[$], wr_q[$], dn_q[$];
    exp_t        me;
    logic [31:0] model [16];
    int          n_tests = 0, n_fail = 0, cyc = 0;
    logic        rd_seen = 0, prev_done = 0;
    logic [31:0] rd_val = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Read data is only meaningful the cycle after rd_en; junk elsewhere exposes mistimed captures
    always @(posedge i_clk) begin
        #1;
        i_reg_rd_data = rd_seen ? rd_val : $urandom;
    end

    always @(negedge i_clk) begin
        rd_seen = i_reset_n && o_reg_rd_en;
        if (i_reset_n) begin
            if (o_reg_rd_en) begin
                if (rd_q.size() == 0) check("rd_en_unexpected", {31'b0, o_reg_rd_en}, 32'd0);
                else begin
                    me = rd_q.pop_front();
                    check("rd_index", 32'(o_reg_rd_index), me.a);
                    check("rd_cycle", 32'(cyc), 32'(me.cyc));
                end
            end
            if (o_reg_wr_en) begin
                if (wr_q.size() == 0) check("wr_en_unexpected", {31'b0, o_reg_wr_en}, 32'd0);
                else begin
                    me = wr_q.pop_front();
                    check("wr_index", 32'(o_reg_wr_index), me.a);
                    check("wr_data", o_reg_wr_data, me.b);
                    check("wr_cycle", 32'(cyc), 32'(me.cyc));
                end
            end
            if (o_copro_done && !prev_done) begin
                if (dn_q.size() == 0) check("done_unexpected", {31'b0, o_copro_done}, 32'd0);
                else begin
                    me = dn_q.pop_front();
                    check("undef", {31'b0, o_copro_undef}, me.a);
                    check("cp_ctrl_at_done", o_cp_ctrl, me.b);
                    check("done_cycle", 32'(cyc), 32'(me.cyc));
                end
            end
        end
        prev_done = o_copro_done;
    end

    function automatic logic [31:0] mk(input bit l, input logic [3:0] crn, input logic [3:0] cp, input bit b4);
        return {4'hE, 4'hE, 3'd0, l, crn, 4'd0, cp, 3'd0, b4, 4'd0};
    endfunction

    // kind: 0 undefined/refused, 1 MCR, 2 MRC; abort_at: 0 none, else cycle offset where dav drops
    task automatic req(input logic [31:0] w, input logic [IW-1:0] ri, input logic [31:0] rdd,
                       input logic [4:0] mode, input int abort_at, input int hold);
        int c, kind, ab, lat;
        bit ok;
        logic [3:0] crn;
        crn  = w[19:16];
        kind = (w[27:24] == 4'hE && w[4] && w[11:8] == 4'd15) ? (w[20] ? 2 : 1) : 0;
`ifdef CP_ACCESS_CHECK_EN
        if (mode == USR) kind = 0;
`endif
        ab = abort_at;
        if (kind == 0 && ab > 1) ab = 1;
        if (kind == 2 && ab > 2) ab = 2;
        @(posedge i_clk); #1;
        c = cyc;
        i_copro_dav_ff  = 1;
        i_copro_word_ff = w;
        i_copro_reg_ff  = ri;
        i_cpsr_ff       = {27'($urandom), mode};
        rd_val          = rdd;
        if (kind == 1 && (ab == 0 || ab >= 3)) rd_q.push_back('{c + 2, 32'(ri), 32'd0});
        if (kind == 2 && ab == 0) wr_q.push_back('{c + 2, 32'(ri), crn == 0 ? ID_VALUE : model[crn]});
        if (kind == 1 && ab == 0 && crn != 0 && !RO_MASK[crn]) model[crn] = rdd;
        lat = kind == 1 ? 4 : kind == 2 ? 3 : 2;
        if (ab == 0) dn_q.push_back('{c + lat, {31'b0, kind == 0}, model[1]});
        if (ab != 0) begin
            repeat (ab) begin @(posedge i_clk); #1; end
            i_copro_dav_ff = 0;
            repeat (3) begin @(posedge i_clk); #1; end
            check("abort_done_low", {31'b0, o_copro_done}, 32'd0);
        end else begin
            ok = 0;
            for (int i = 0; i < 8 && !ok; i++) begin
                @(negedge i_clk);
                ok = o_copro_done;
            end
            if (!ok) check("done_timeout", {31'b0, o_copro_done}, 32'd1);
            repeat (hold + 1) begin
                @(posedge i_clk); #1;
                check("done_held", {31'b0, o_copro_done}, 32'd1);
            end
            i_copro_dav_ff = 0;
            @(posedge i_clk); #1;
            check("done_cleared", {31'b0, o_copro_done}, 32'd0);
            check("undef_cleared", {31'b0, o_copro_undef}, 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"}, {31'b0, o_copro_done}, 32'd0);
        check({tag, "_undef"}, {31'b0, o_copro_undef}, 32'd0);
        check({tag, "_rd_en"}, {31'b0, o_reg_rd_en}, 32'd0);
        check({tag, "_wr_en"}, {31'b0, o_reg_wr_en}, 32'd0);
        check({tag, "_rd_index"}, 32'(o_reg_rd_index), 32'd0);
        check({tag, "_wr_index"}, 32'(o_reg_wr_index), 32'd0);
        check({tag, "_wr_data"}, o_reg_wr_data, 32'd0);
        check({tag, "_cp_ctrl"}, o_cp_ctrl, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        int sel;
        for (int i = 0; i < 16; i++) model[i] = 0;
        #3;
        check_all_zero("reset");
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1;

        req(mk(0, 4'd1, 4'd15, 1), 6'd3, 32'hDEAD_BEEF, SVC, 0, 0);
        req(mk(1, 4'd0, 4'd15, 1), 6'd7, 32'h0, SVC, 0, 0);
        req(mk(0, 4'd2, 4'd15, 0), 6'd1, 32'h1111_1111, SVC, 0, 0);
        req(mk(0, 4'd1, 4'd14, 1), 6'd2, 32'h2222_2222, SVC, 0, 0);
        req(mk(0, 4'd0, 4'd15, 1), 6'd4, 32'h3333_3333, SVC, 0, 0);
        req(mk(1, 4'd1, 4'd15, 1), 6'd9, 32'h0, SVC, 0, 5);
        req(mk(1, 4'd1, 4'd15, 1), 6'd5, 32'h0, SVC, 2, 0);
        req(mk(0, 4'd2, 4'd15, 1), 6'd8, 32'hAAAA_5555, SVC, 3, 0);
        req(mk(0, 4'd1, 4'd15, 1), 6'd8, 32'h1234_5678, USR, 0, 0);
        req(mk(1, 4'd1, 4'd15, 1), 6'd45, 32'h0, SVC, 0, 1);
        req(mk(1, 4'd2, 4'd15, 1), 6'd10, 32'h0, SVC, 0, 0);

        // async reset in the CAPTURE cycle of an MCR
        @(posedge i_clk); #1;
        rd_q.push_back('{cyc + 2, 32'd4, 32'd0});
        i_copro_dav_ff  = 1;
        i_copro_word_ff = mk(0, 4'd3, 4'd15, 1);
        i_copro_reg_ff  = 6'd4;
        i_cpsr_ff       = {27'd0, SVC};
        rd_val          = 32'hCAFE_F00D;
        repeat (3) begin @(posedge i_clk); #1; end
        i_reset_n = 0;
        #1;
        check_all_zero("mid_reset");
        for (int i = 0; i < 16; i++) model[i] = 0;
        i_copro_dav_ff = 0;
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1;
        repeat (3) begin @(posedge i_clk); #1; end
        check("post_reset_done", {31'b0, o_copro_done}, 32'd0);
        req(mk(1, 4'd3, 4'd15, 1), 6'd11, 32'h0, SVC, 0, 0);
        req(mk(1, 4'd1, 4'd15, 1), 6'd12, 32'h0, SVC, 0, 0);

        for (int n = 0; n < 200; n++) begin
            w   = $urandom;
            sel = $urandom_range(0, 4);
            if (sel <= 2) begin
                w[27:24] = 4'hE;
                w[4]     = 1'b1;
                w[11:8]  = 4'd15;
                w[20]    = sel == 1;
            end
            if (sel == 2) w[11:8] = 4'($urandom_range(0, 14));
            if (sel == 3) begin
                w[27:24] = 4'hE;
                w[4]     = 1'b0;
            end
            req(w, IW'($urandom_range(0, PHY_REGS - 1)), $urandom,
                $urandom_range(0, 1) ? USR : SVC,
                $urandom_range(0, 4) == 0 ? $urandom_range(1, 3) : 0,
                $urandom_range(0, 5));
        end

        repeat (4) @(posedge i_clk);
        check("pending_expectations", 32'(rd_q.size() + wr_q.size() + dn_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
